// File: rtl/mario_pkg.sv
// Shared definitions for the Mario motion controller and the colour mapper:
// motion state encoding, HID keycodes, screen size, the girder floor table,
// the ladder table and small geometry helpers.
package mario_pkg;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned N_FLOORS  = 6;
  localparam int unsigned N_LADDERS = 7;

  typedef enum logic [2:0] {
    ST_STAND = 3'd0,
    ST_WALK  = 3'd1,
    ST_JUMP  = 3'd2,
    ST_FALL  = 3'd3,
    ST_CLIMB = 3'd4
  } mario_state_t;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef struct packed {
    logic [9:0] top;
    logic [9:0] xmin;
    logic [9:0] xmax;
  } floor_t;

  // lower = index of the floor at the ladder foot; the top is floor lower+1
  typedef struct packed {
    logic [2:0] lower;
    logic [9:0] xmin;
    logic [9:0] xmax;
  } ladder_t;

  localparam floor_t FLOORS [N_FLOORS] = '{
    '{10'd430, 10'd31, 10'd609},
    '{10'd370, 10'd31, 10'd559},
    '{10'd310, 10'd81, 10'd609},
    '{10'd250, 10'd31, 10'd559},
    '{10'd190, 10'd81, 10'd609},
    '{10'd130, 10'd31, 10'd559}
  };

  localparam ladder_t LADDERS [N_LADDERS] = '{
    '{3'd0, 10'd301, 10'd314},
    '{3'd0, 10'd536, 10'd549},
    '{3'd1, 10'd101, 10'd114},
    '{3'd2, 10'd251, 10'd264},
    '{3'd2, 10'd501, 10'd514},
    '{3'd3, 10'd121, 10'd134},
    '{3'd4, 10'd536, 10'd549}
  };

  function automatic logic signed [10:0] s11(input logic [9:0] v);
    return $signed({1'b0, v});
  endfunction

  function automatic logic in_span(input logic signed [10:0] x,
                                   input logic [9:0] lo, input logic [9:0] hi);
    return (x >= s11(lo)) && (x <= s11(hi));
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the vsync-derived frame level into the Clk domain and emits a
// one-cycle strobe on its rising edge.
//   i_clk   : system clock
//   i_rst   : synchronous active-high reset
//   i_async : frame level, asynchronous to i_clk
//   o_tick  : one-cycle pulse per frame_clk rising edge
module frame_tick_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_tick
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_tick = r_sync2 & ~r_prev;

endmodule

// File: rtl/mario_motion.sv
// Per-frame player motion controller feeding color_mapper. Walks, jumps,
// falls and climbs the sprite over the girder/ladder level once per frame.
//   Clk, Reset          : system clock, synchronous active-high reset
//   frame_clk           : asynchronous frame level, one update per rising edge
//   keycode             : HID keycode (A/D/W/S/space, anything else = none)
//   BallX, BallY        : sprite centre
//   Ball_size           : sprite half-extent (constant SIZE)
//   facing_left         : last horizontal input was left
//   mario_state         : STAND/WALK/JUMP/FALL/CLIMB for sprite selection
module mario_motion
  import mario_pkg::*;
#(
  parameter int SIZE     = 16,
  parameter int START_X  = 60,
  parameter int START_Y  = 414,
  parameter int WALK_SPD = 1,
  parameter int JUMP_V0  = -5,
  parameter int VMAX     = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_size,
  output logic       facing_left,
  output logic [2:0] mario_state
);

  localparam logic signed [10:0] C_SIZE = 11'(SIZE);
  localparam logic signed [10:0] C_XMAX = 11'(int'(SCREEN_W) - 1 - SIZE);
  localparam logic signed [10:0] C_YMAX = 11'(int'(SCREEN_H) - 1);
  localparam logic signed [10:0] C_WSPD = 11'(WALK_SPD);
  localparam logic signed [4:0]  C_V0   = 5'(JUMP_V0);
  localparam logic signed [4:0]  C_VMAX = 5'(VMAX);

  // Negative results saturate to 0 rather than wrapping.
  function automatic logic [9:0] to_u10(input logic signed [10:0] v);
    return v[10] ? '0 : v[9:0];
  endfunction

  logic w_tick;

  frame_tick_sync u_tick (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_async (frame_clk),
    .o_tick  (w_tick)
  );

  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic signed [4:0] r_vy;
  logic signed [1:0] r_jd;
  logic              r_face;
  logic [2:0]        r_lad;
  mario_state_t      r_state;

  logic signed [10:0] w_x, w_y, w_feet, w_nx, w_ny, w_tx, w_ty, w_nfeet, w_lo, w_hi;
  logic signed [4:0]  w_nvy, w_vstep;
  logic signed [1:0]  w_njd;
  logic               w_nface, w_air, w_on, w_cur_ok;
  logic [2:0]         w_cur_idx, w_nlad;
  mario_state_t       w_nst;

  always_comb begin
    w_x       = s11(r_x);
    w_y       = s11(r_y);
    w_feet    = w_y + C_SIZE;
    w_nx      = w_x;
    w_ny      = w_y;
    w_nvy     = r_vy;
    w_njd     = r_jd;
    w_nface   = r_face;
    w_nst     = r_state;
    w_nlad    = r_lad;
    w_air     = 1'b0;
    w_vstep   = r_vy;
    w_tx      = '0;
    w_ty      = '0;
    w_nfeet   = '0;
    w_lo      = '0;
    w_hi      = '0;
    w_on      = 1'b0;
    w_cur_ok  = 1'b0;
    w_cur_idx = '0;

    for (int unsigned k = 0; k < N_FLOORS; k++) begin
      if (w_feet == s11(FLOORS[k].top) && in_span(w_x, FLOORS[k].xmin, FLOORS[k].xmax)) begin
        w_cur_ok  = 1'b1;
        w_cur_idx = 3'(k);
      end
    end

    case (r_state)
      ST_STAND, ST_WALK: begin
        w_nst = ST_STAND;
        w_njd = '0;
        w_nvy = '0;
        case (keycode)
          KEY_A: begin
            w_nx = w_x - C_WSPD;
            if (w_nx < C_SIZE) w_nx = C_SIZE;
            w_nst   = ST_WALK;
            w_nface = 1'b1;
          end
          KEY_D: begin
            w_nx = w_x + C_WSPD;
            if (w_nx > C_XMAX) w_nx = C_XMAX;
            w_nst   = ST_WALK;
            w_nface = 1'b0;
          end
          KEY_SPACE: begin
            // The launch frame already applies the first airborne step.
            w_air   = 1'b1;
            w_vstep = C_V0;
            w_nst   = ST_JUMP;
            if (r_state == ST_WALK) w_njd = r_face ? -2'sd1 : 2'sd1;
          end
          KEY_W: begin
            if (w_cur_ok) begin
              for (int unsigned l = 0; l < N_LADDERS; l++) begin
                if (LADDERS[l].lower == w_cur_idx &&
                    in_span(w_x, LADDERS[l].xmin, LADDERS[l].xmax)) begin
                  w_nst  = ST_CLIMB;
                  w_nlad = 3'(l);
                end
              end
            end
          end
          KEY_S: begin
            if (w_cur_ok) begin
              for (int unsigned l = 0; l < N_LADDERS; l++) begin
                if (LADDERS[l].lower + 3'd1 == w_cur_idx &&
                    in_span(w_x, LADDERS[l].xmin, LADDERS[l].xmax)) begin
                  w_nst  = ST_CLIMB;
                  w_nlad = 3'(l);
                end
              end
            end
          end
          default: ;
        endcase
        if (!w_air && w_nst != ST_CLIMB) begin
          for (int unsigned k = 0; k < N_FLOORS; k++) begin
            if (w_feet == s11(FLOORS[k].top) &&
                in_span(w_nx, FLOORS[k].xmin, FLOORS[k].xmax))
              w_on = 1'b1;
          end
          if (!w_on) begin
            w_nst = ST_FALL;
            w_nvy = '0;
          end
        end
      end
      ST_JUMP, ST_FALL: w_air = 1'b1;
      ST_CLIMB: begin
        w_lo = s11(FLOORS[LADDERS[r_lad].lower].top);
        w_hi = s11(FLOORS[LADDERS[r_lad].lower + 3'd1].top);
        if (keycode == KEY_W && w_feet != w_hi)      w_ny = w_y - 11'sd1;
        else if (keycode == KEY_S && w_feet != w_lo) w_ny = w_y + 11'sd1;
        w_nfeet = w_ny + C_SIZE;
        if (w_nfeet == w_hi || w_nfeet == w_lo) w_nst = ST_STAND;
      end
      default: w_nst = ST_STAND;
    endcase

    if (w_air) begin
      w_tx = w_nx;
      if (w_njd == 2'sd1)       w_tx = w_nx + C_WSPD;
      else if (w_njd == -2'sd1) w_tx = w_nx - C_WSPD;
      if (w_tx < C_SIZE) begin
        w_tx  = C_SIZE;
        w_njd = '0;
      end else if (w_tx > C_XMAX) begin
        w_tx  = C_XMAX;
        w_njd = '0;
      end
      w_nx    = w_tx;
      w_ty    = w_y + $signed({{6{w_vstep[4]}}, w_vstep});
      w_nvy   = (w_vstep >= C_VMAX) ? C_VMAX : w_vstep + 5'sd1;
      w_nst   = (w_nvy > 5'sd0) ? ST_FALL : ST_JUMP;
      w_nfeet = w_ty + C_SIZE;
      // Landing only while descending and when the feet crossed a top this frame.
      if (w_vstep > 5'sd0) begin
        for (int unsigned k = 0; k < N_FLOORS; k++) begin
          if (w_feet < s11(FLOORS[k].top) && s11(FLOORS[k].top) <= w_nfeet &&
              in_span(w_nx, FLOORS[k].xmin, FLOORS[k].xmax)) begin
            w_ty  = s11(FLOORS[k].top) - C_SIZE;
            w_nvy = '0;
            w_njd = '0;
            w_nst = ST_STAND;
          end
        end
      end
      if (w_ty < C_SIZE) begin
        w_ty  = C_SIZE;
        w_nvy = '0;
        w_nst = ST_FALL;
      end else if (w_ty > C_YMAX) begin
        w_ty = C_YMAX;
      end
      w_ny = w_ty;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_x     <= 10'(START_X);
      r_y     <= 10'(START_Y);
      r_vy    <= '0;
      r_jd    <= '0;
      r_face  <= 1'b0;
      r_lad   <= '0;
      r_state <= ST_STAND;
    end else if (w_tick) begin
      r_x     <= to_u10(w_nx);
      r_y     <= to_u10(w_ny);
      r_vy    <= w_nvy;
      r_jd    <= w_njd;
      r_face  <= w_nface;
      r_lad   <= w_nlad;
      r_state <= w_nst;
    end
  end

  assign BallX       = r_x;
  assign BallY       = r_y;
  assign Ball_size   = 10'(SIZE);
  assign facing_left = r_face;
  assign mario_state = r_state;

endmodule
